btb_sa: RTL
===========

Name: btb_sa

Overview:
Parametrised set-associative branch target buffer serving FETCH_PORTS independent lookups per cycle. Predicted target and instruction type are returned on registered outputs one cycle after the request. It sits beside the fetch stage and takes one update per cycle from the branch-resolution path (install, overwrite or invalidate). A multi-cycle flush sweep clears the whole buffer on demand, for example on context change or icache maintenance.

Parameters:
FETCH_PORTS, 2, number of parallel lookup ports
SETS, 16, number of sets; power of two, at least 2
WAYS, 2, ways per set; power of two, at least 2
TAGLEN, 8, stored tag width
TYPELEN, 3, instruction-type field width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_valid  in  FETCH_PORTS  lookup request per port
fetch_pc  in  32*FETCH_PORTS  lookup PC; port p occupies bits [32p+31:32p]
resp_valid  out  FETCH_PORTS  registered copy of fetch_valid
resp_hit  out  FETCH_PORTS  lookup hit
resp_target  out  32*FETCH_PORTS  predicted target; 0 on miss
resp_type  out  TYPELEN*FETCH_PORTS  instruction type; 0 on miss
upd_valid  in  1  update request
upd_ready  out  1  update accepted; low while flushing
upd_pc  in  32  branch PC
upd_target  in  32  resolved target
upd_type  in  TYPELEN  resolved instruction type
upd_inval  in  1  remove the entry for upd_pc instead of writing it
flush  in  1  one-cycle pulse; starts the invalidate sweep
busy  out  1  sweep in progress

Behaviour:
- IB = log2(SETS). Set index = pc[IB+1:2].
- Tag: pc[31:IB+2] is zero-extended to a multiple of TAGLEN, then all TAGLEN-bit chunks are XOR-folded together.
- Storage per entry: valid, tag, target, type. Per set: round-robin pointer rr, log2(WAYS) bits wide.
- Reset: all valid bits clear and all rr values 0 in the same cycle. Outputs after reset: resp_valid=0, resp_hit=0, resp_target=0, resp_type=0, busy=0, upd_ready=1. FSM returns to IDLE.
- Lookup:
  - A request at cycle N produces its response at the N+1 edge and holds it until the next edge.
  - A way hits when valid and its tag equals the computed tag. If more than one way matches, the lowest-numbered way wins (not reachable in normal use).
  - When fetch_valid=0, resp_hit=0 and resp_target/resp_type=0.
- Update: the operation is performed when upd_valid && upd_ready.
  - upd_inval=1: clear valid of the hit way. No effect on a miss. rr is unchanged.
  - Write on a hit: overwrite target and type in place. rr is unchanged.
  - Write on a miss with at least one invalid way: allocate the lowest invalid way. rr is unchanged.
  - Write on a miss with the set full: replace way rr[set], then rr[set] <= rr[set]+1, wrapping modulo WAYS.
  - Storage is written at the end of the cycle. A lookup in the same cycle as an update sees the old contents; a lookup in the next cycle sees the new contents. No bypass.
- Flush FSM:
  - IDLE --flush--> SWEEP, with sweep counter set to 0.
  - In SWEEP, each cycle clears valid for every way of set[cnt] and sets rr[cnt]=0.
  - At cnt=SETS-1 the FSM returns to IDLE. The sweep takes exactly SETS cycles.
  - busy=1 and upd_ready=0 throughout SWEEP.
  - Any lookup issued in SWEEP returns resp_hit=0.
  - A flush pulse arriving during SWEEP restarts the counter at 0.
  - Reset during SWEEP aborts the sweep; reset behaviour applies.
- Flush and upd_valid in the same IDLE cycle: the flush wins and the update is not accepted (upd_ready is already 0 in the following cycle, so upd_ready is combinational: it is low when the FSM is in SWEEP or flush=1).

Test Plan:
1. Post-reset miss: reset 2 cycles, then lookup port0 pc=0x1C000000 -> next cycle resp_valid=1, resp_hit=0, resp_target=0, resp_type=0; busy=0, upd_ready=1.
2. Install then dual-port hit (SETS=16, WAYS=2): update pc=0x1C000010, target=0x1C000100, type=3. One cycle later, both ports look up 0x1C000010 -> both resp_hit=1, target 0x1C000100, type 3. A lookup in the same cycle as the update -> miss.
3. Replacement: install A=0x1C000010, B=0x1C000050, C=0x1C000090 (all set 4) -> A in way 0, B in way 1; C replaces way 0 and rr[4] becomes 1. Lookup A misses, B and C hit. Then install D=0x1C0000D0 -> replaces B in way 1, rr[4] wraps to 0.
4. Overwrite and invalidate: update C with target 0x1C000200 -> hit returns 0x1C000200, rr unchanged. Invalidate C -> C misses. Install E=0x1C000110 -> goes to the freed way 0, rr unchanged.
5. Flush: fill 3 sets, pulse flush -> busy=1 for exactly 16 cycles, upd_ready=0, and an update offered during the sweep is not applied. All lookups miss during and after the sweep; all rr are 0.
6. Flush restart and reset abort: flush pulse at sweep cycle 5 -> busy lasts 16 more cycles. Reset during a sweep -> busy=0 next cycle and all entries miss.

Source files
------------

// File: rtl/btb_sa_if.sv
// Fetch-lookup, branch-update and flush signals shared between the fetch
// front end (master) and the branch target buffer (slave).
interface btb_sa_if #(
  parameter int FETCH_PORTS = 2,
  parameter int TYPELEN     = 3
);
  logic [FETCH_PORTS-1:0]         fetch_valid;
  logic [32*FETCH_PORTS-1:0]      fetch_pc;
  logic [FETCH_PORTS-1:0]         resp_valid;
  logic [FETCH_PORTS-1:0]         resp_hit;
  logic [32*FETCH_PORTS-1:0]      resp_target;
  logic [TYPELEN*FETCH_PORTS-1:0] resp_type;
  logic                           upd_valid;
  logic                           upd_ready;
  logic [31:0]                    upd_pc;
  logic [31:0]                    upd_target;
  logic [TYPELEN-1:0]             upd_type;
  logic                           upd_inval;
  logic                           flush;
  logic                           busy;

  modport master (
    output fetch_valid, fetch_pc, upd_valid, upd_pc, upd_target, upd_type,
           upd_inval, flush,
    input  resp_valid, resp_hit, resp_target, resp_type, upd_ready, busy
  );

  modport slave (
    input  fetch_valid, fetch_pc, upd_valid, upd_pc, upd_target, upd_type,
           upd_inval, flush,
    output resp_valid, resp_hit, resp_target, resp_type, upd_ready, busy
  );
endinterface

// File: rtl/btb_sa.sv
// Set-associative branch target buffer: multi-port registered lookup,
// one update per cycle, round-robin replacement, multi-cycle flush sweep.
module btb_sa #(
  parameter int FETCH_PORTS = 2,
  parameter int SETS        = 16,
  parameter int WAYS        = 2,
  parameter int TAGLEN      = 8,
  parameter int TYPELEN     = 3
) (
  input logic     clk,
  input logic     reset,
  btb_sa_if.slave bus
);
  localparam int IB  = $clog2(SETS);
  localparam int WB  = $clog2(WAYS);
  localparam int HIW = 30 - IB;
  localparam int NCH = (HIW + TAGLEN - 1) / TAGLEN;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t          state_q, state_d;
  logic [IB-1:0]   cnt_q, cnt_d;

  logic [WAYS-1:0]    valid_q [SETS];
  logic [TAGLEN-1:0]  tag_q   [SETS][WAYS];
  logic [31:0]        tgt_q   [SETS][WAYS];
  logic [TYPELEN-1:0] typ_q   [SETS][WAYS];
  logic [WB-1:0]      rr_q    [SETS];

  logic [FETCH_PORTS-1:0]         hit_c;
  logic [32*FETCH_PORTS-1:0]      tgt_c;
  logic [TYPELEN*FETCH_PORTS-1:0] typ_c;
  logic [IB-1:0]                  lk_set;
  logic [TAGLEN-1:0]              lk_tag;
  logic                           unused_pc_lsb;

  logic [IB-1:0]     u_set;
  logic [TAGLEN-1:0] u_tag;
  logic              u_hit, u_free, upd_fire;
  logic [WB-1:0]     u_hit_way, u_free_way, u_way;

  // Upper PC bits, zero-extended to whole chunks and XOR-folded to TAGLEN.
  function automatic logic [TAGLEN-1:0] fold_tag(input logic [31:0] pc);
    logic [NCH*TAGLEN-1:0] ext;
    logic [TAGLEN-1:0]     acc;
    ext          = '0;
    ext[HIW-1:0] = pc[31:IB+2];
    acc          = '0;
    for (int unsigned i = 0; i < NCH; i++) acc ^= ext[i*TAGLEN +: TAGLEN];
    return acc;
  endfunction

  assign bus.busy      = (state_q == SWEEP);
  assign bus.upd_ready = (state_q == IDLE) && !bus.flush;
  assign upd_fire      = bus.upd_valid && bus.upd_ready;

  // Per-port tag compare; lowest matching way wins, suppressed while sweeping.
  always_comb begin
    hit_c         = '0;
    tgt_c         = '0;
    typ_c         = '0;
    lk_set        = '0;
    lk_tag        = '0;
    unused_pc_lsb = 1'b0;
    for (int unsigned p = 0; p < FETCH_PORTS; p++) begin
      lk_set        = bus.fetch_pc[32*p+2 +: IB];
      lk_tag        = fold_tag(bus.fetch_pc[32*p +: 32]);
      unused_pc_lsb = unused_pc_lsb ^ (^bus.fetch_pc[32*p +: 2]);
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (!hit_c[p] && valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
          hit_c[p]                   = 1'b1;
          tgt_c[32*p +: 32]          = tgt_q[lk_set][w];
          typ_c[TYPELEN*p +: TYPELEN] = typ_q[lk_set][w];
        end
      end
      if (!bus.fetch_valid[p] || (state_q == SWEEP)) begin
        hit_c[p]                    = 1'b0;
        tgt_c[32*p +: 32]           = '0;
        typ_c[TYPELEN*p +: TYPELEN] = '0;
      end
    end
  end

  // Registered lookup response.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_valid  <= '0;
      bus.resp_hit    <= '0;
      bus.resp_target <= '0;
      bus.resp_type   <= '0;
    end else begin
      bus.resp_valid  <= bus.fetch_valid;
      bus.resp_hit    <= hit_c;
      bus.resp_target <= tgt_c;
      bus.resp_type   <= typ_c;
    end
  end

  // Update-side way selection: hit way, else lowest free way, else rr victim.
  always_comb begin
    u_set      = bus.upd_pc[IB+1:2];
    u_tag      = fold_tag(bus.upd_pc);
    u_hit      = 1'b0;
    u_free     = 1'b0;
    u_hit_way  = '0;
    u_free_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!u_hit && valid_q[u_set][w] && (tag_q[u_set][w] == u_tag)) begin
        u_hit     = 1'b1;
        u_hit_way = WB'(w);
      end
      if (!u_free && !valid_q[u_set][w]) begin
        u_free     = 1'b1;
        u_free_way = WB'(w);
      end
    end
    u_way = u_hit ? u_hit_way : (u_free ? u_free_way : rr_q[u_set]);
  end

  // Storage: reset/sweep clear valid and rr; otherwise apply an accepted update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (state_q == SWEEP) begin
      valid_q[cnt_q] <= '0;
      rr_q[cnt_q]    <= '0;
    end else if (upd_fire) begin
      if (bus.upd_inval) begin
        if (u_hit) valid_q[u_set][u_hit_way] <= 1'b0;
      end else begin
        valid_q[u_set][u_way] <= 1'b1;
        tag_q[u_set][u_way]   <= u_tag;
        tgt_q[u_set][u_way]   <= bus.upd_target;
        typ_q[u_set][u_way]   <= bus.upd_type;
        if (!u_hit && !u_free) rr_q[u_set] <= rr_q[u_set] + 1'b1;
      end
    end
  end

  // Flush FSM state register and sweep counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush FSM next state; a flush during the sweep restarts it from set 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (bus.flush) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
